// File: rtl/muldiv_unit_pkg.sv
// Shared types for the iterative multiply/divide unit: request opcodes,
// controller states and the fixed iteration count.
package muldiv_unit_pkg;

  localparam int MULDIV_ITERS = 32;

  // Requests issued by the execute stage; unlisted encodings are ignored.
  typedef enum logic [2:0] {
    OP_NONE = 3'd0,
    OP_MUL  = 3'd1,
    OP_MADD = 3'd2,
    OP_DIV  = 3'd3,
    OP_MTHI = 3'd4,
    OP_MTLO = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    MD_IDLE,
    MD_MUL,
    MD_DIV,
    MD_FIX
  } muldiv_state_t;

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Radix-2 shift-add multiply and restoring divide run on operand magnitudes;
// a single FIX cycle applies signs, accumulates (MADD) and commits HI/LO.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITERS = WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  muldiv_op_t       req_op,
  input  logic             req_unsigned,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             flush,
  output logic             busy,
  output logic             resp_valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (ITERS > 1) ? $clog2(ITERS) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(ITERS - 1);

  // Conditional two's-complement negate; also used to take magnitudes.
  // The most negative value maps onto itself, which is the correct
  // unsigned magnitude for the iterations.
  function automatic logic [WIDTH-1:0] neg_if(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  muldiv_state_t state_reg, state_next;

  // prod_reg holds {partial product, multiplier} during MUL and
  // {remainder, dividend/quotient} during DIV.
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH-1:0]   opb_reg;
  logic [CW-1:0]      count_reg;
  logic               neg_reg;
  logic               rem_neg_reg;
  logic               madd_reg;
  logic               div_reg;
  logic [WIDTH-1:0]   hi_reg;
  logic [WIDTH-1:0]   lo_reg;
  logic               resp_valid_reg;

  logic               accept;
  logic               a_sign;
  logic               b_sign;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     mul_addend;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] prod_fix;
  logic [2*WIDTH-1:0] madd_sum;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  assign req_ready  = (state_reg == MD_IDLE);
  assign busy       = ~req_ready;
  assign resp_valid = resp_valid_reg;
  assign hi         = hi_reg;
  assign lo         = lo_reg;

  assign accept = req_valid & req_ready & ~flush;
  assign a_sign = req_a[WIDTH-1] & ~req_unsigned;
  assign b_sign = req_b[WIDTH-1] & ~req_unsigned;
  assign a_mag  = neg_if(req_a, a_sign);
  assign b_mag  = neg_if(req_b, b_sign);

  // One shift-add multiply step and one restoring divide step.
  always_comb begin
    mul_addend = prod_reg[0] ? {1'b0, opb_reg} : '0;
    mul_sum    = {1'b0, prod_reg[2*WIDTH-1:WIDTH]} + mul_addend;
    mul_step   = {mul_sum, prod_reg[WIDTH-1:1]};
    div_shift  = prod_reg[2*WIDTH-1:WIDTH-1];
    div_diff   = div_shift - {1'b0, opb_reg};
    if (div_diff[WIDTH]) begin
      div_step = {div_shift[WIDTH-1:0], prod_reg[WIDTH-2:0], 1'b0};
    end else begin
      div_step = {div_diff[WIDTH-1:0], prod_reg[WIDTH-2:0], 1'b1};
    end
  end

  // Sign fix-up and MADD accumulation applied in the FIX cycle.
  always_comb begin
    prod_fix = neg_reg ? (~prod_reg + 1'b1) : prod_reg;
    madd_sum = {hi_reg, lo_reg} + prod_fix;
    quo_fix  = neg_if(prod_reg[WIDTH-1:0], neg_reg);
    rem_fix  = neg_if(prod_reg[2*WIDTH-1:WIDTH], rem_neg_reg);
  end

  // Controller state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= MD_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      MD_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MUL, OP_MADD: state_next = MD_MUL;
            OP_DIV:          state_next = MD_DIV;
            default:         state_next = MD_IDLE;
          endcase
        end
      end
      MD_MUL, MD_DIV: begin
        if (count_reg == LAST_COUNT) begin
          state_next = MD_FIX;
        end
      end
      MD_FIX:  state_next = MD_IDLE;
      default: state_next = MD_IDLE;
    endcase
    if (flush) begin
      state_next = MD_IDLE;
    end
  end

  // Datapath: operand capture, iteration steps and HI/LO commit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prod_reg       <= '0;
      opb_reg        <= '0;
      count_reg      <= '0;
      neg_reg        <= 1'b0;
      rem_neg_reg    <= 1'b0;
      madd_reg       <= 1'b0;
      div_reg        <= 1'b0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      resp_valid_reg <= 1'b0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        MD_IDLE: begin
          if (accept) begin
            case (req_op)
              OP_MUL, OP_MADD, OP_DIV: begin
                prod_reg    <= {{WIDTH{1'b0}}, a_mag};
                opb_reg     <= b_mag;
                count_reg   <= '0;
                neg_reg     <= a_sign ^ b_sign;
                rem_neg_reg <= a_sign;
                madd_reg    <= (req_op == OP_MADD);
                div_reg     <= (req_op == OP_DIV);
              end
              OP_MTHI: begin
                hi_reg         <= req_a;
                resp_valid_reg <= 1'b1;
              end
              OP_MTLO: begin
                lo_reg         <= req_a;
                resp_valid_reg <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        MD_MUL: begin
          prod_reg  <= mul_step;
          count_reg <= count_reg + 1'b1;
        end
        MD_DIV: begin
          prod_reg  <= div_step;
          count_reg <= count_reg + 1'b1;
        end
        MD_FIX: begin
          if (!flush) begin
            resp_valid_reg <= 1'b1;
            if (div_reg) begin
              hi_reg <= rem_fix;
              lo_reg <= quo_fix;
            end else if (madd_reg) begin
              {hi_reg, lo_reg} <= madd_sum;
            end else begin
              {hi_reg, lo_reg} <= prod_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: a reference model pushes expected
// {hi,lo} values into a scoreboard queue at issue time; they are popped and
// compared when the unit pulses resp_valid.
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  muldiv_op_t  req_op = OP_NONE;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        resp_valid;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad = 0;
  logic [63:0] exp_q[$];
  logic [31:0] mdl_hi = '0;
  logic [31:0] mdl_lo = '0;

  muldiv_unit #(.WIDTH(32), .ITERS(32)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_unsigned(req_unsigned),
    .req_a       (req_a),
    .req_b       (req_b),
    .flush       (flush),
    .busy        (busy),
    .resp_valid  (resp_valid),
    .hi          (hi),
    .lo          (lo)
  );

  always #5 clock = ~clock;

  // Reference model of the architectural effect of one request on {hi,lo}.
  function automatic logic [63:0] model(muldiv_op_t op, logic uns, logic [31:0] a,
                                        logic [31:0] b, logic [63:0] hilo);
    logic [63:0] ea, eb, p;
    logic signed [31:0] sa, sb, sq, sr;
    ea = uns ? {32'b0, a} : {{32{a[31]}}, a};
    eb = uns ? {32'b0, b} : {{32{b[31]}}, b};
    p  = ea * eb;
    case (op)
      OP_MUL:  return p;
      OP_MADD: return hilo + p;
      OP_DIV: begin
        if (b == 32'd0) begin
          if (uns || !a[31]) return {a, 32'hFFFF_FFFF};
          return {a, 32'h0000_0001};
        end
        if (uns) return {a % b, a / b};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        sq = sa / sb;
        sr = sa % sb;
        return {sr, sq};
      end
      OP_MTHI: return {a, hilo[31:0]};
      OP_MTLO: return {hilo[63:32], a};
      default: return hilo;
    endcase
  endfunction

  // Present one request at a negedge; returns at the negedge after the accept edge.
  task automatic issue(muldiv_op_t op, logic uns, logic [31:0] a, logic [31:0] b, bit track);
    logic [63:0] e;
    req_valid = 1'b1;
    req_op = op;
    req_unsigned = uns;
    req_a = a;
    req_b = b;
    if (track) begin
      e = model(op, uns, a, b, {mdl_hi, mdl_lo});
      exp_q.push_back(e);
      {mdl_hi, mdl_lo} = e;
    end
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    req_op = OP_NONE;
  endtask

  // Wait for resp_valid. lat counts the accept edge as 1, so a mul/div that
  // commits at E33 is seen with lat = 34. busy_cnt counts busy-high samples.
  task automatic wait_resp(output int lat, output int busy_cnt, output bit timeout);
    lat = 1;
    busy_cnt = busy ? 1 : 0;
    timeout = 1'b0;
    while (!resp_valid) begin
      if (lat >= 100) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clock);
      @(negedge clock);
      lat++;
      if (busy) busy_cnt++;
    end
  endtask

  // Issue, wait, and pop the scoreboard entry; got is X on timeout.
  task automatic do_op(muldiv_op_t op, logic uns, logic [31:0] a, logic [31:0] b,
                       output logic [63:0] got, output logic [63:0] exp, output int lat,
                       output int busy_cnt);
    bit to;
    issue(op, uns, a, b, 1'b1);
    wait_resp(lat, busy_cnt, to);
    got = to ? 64'hx : {hi, lo};
    exp = exp_q.pop_front();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    total++;
    if ({hi, lo, resp_valid, busy, req_ready} !== {64'h0, 3'b001})
      begin bad++; $display("FAIL reset_in: got hi=%h lo=%h rv=%b busy=%b rdy=%b want 0/0/0/0/1", hi, lo, resp_valid, busy, req_ready); end
    reset_n = 1'b1;
    @(negedge clock);
    total++;
    if ({hi, lo, resp_valid, busy, req_ready} !== {64'h0, 3'b001})
      begin bad++; $display("FAIL reset_out: got hi=%h lo=%h rv=%b busy=%b rdy=%b want 0/0/0/0/1", hi, lo, resp_valid, busy, req_ready); end
  endtask

  task automatic test_mul_unsigned();
    logic [63:0] got, exp;
    int lat, bc;
    do_op(OP_MUL, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, got, exp, lat, bc);
    $display("mulu ffffffff*ffffffff -> %h lat=%0d", got, lat);
    total++;
    if (lat != MULDIV_ITERS + 2) begin bad++; $display("FAIL mul_latency: got %0d want %0d", lat, MULDIV_ITERS + 2); end
    total++;
    if (bc != lat - 1 || busy !== 1'b0) begin bad++; $display("FAIL mul_busy: got %0d cycles busy_now=%b want %0d cycles busy_now=0", bc, busy, lat - 1); end
    total++;
    if (got !== exp) begin bad++; $display("FAIL mulu_model: got %h want %h", got, exp); end
    total++;
    if (got !== 64'hFFFF_FFFE_0000_0001) begin bad++; $display("FAIL mulu_const: got %h want fffffffe00000001", got); end
    total++;
    if (req_ready !== 1'b1) begin bad++; $display("FAIL ready_after_fix: got %b want 1", req_ready); end
    @(negedge clock);
    total++;
    if (resp_valid !== 1'b0) begin bad++; $display("FAIL resp_pulse: got %b want 0", resp_valid); end
  endtask

  task automatic test_mul_signed_madd();
    logic [63:0] got, exp;
    int lat, bc;
    do_op(OP_MUL, 1'b0, -32'sd3, 32'd7, got, exp, lat, bc);
    $display("mult -3*7 -> %h", got);
    total++;
    if (got !== exp || got !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL mult_signed: got %h want ffffffffffffffeb", got); end
    do_op(OP_MADD, 1'b0, 32'd2, 32'd3, got, exp, lat, bc);
    $display("madd +2*3 -> %h", got);
    total++;
    if (got !== exp || got !== 64'hFFFF_FFFF_FFFF_FFF1) begin bad++; $display("FAIL madd_signed: got %h want fffffffffffffff1", got); end
  endtask

  task automatic test_div();
    logic [63:0] got, exp;
    int lat, bc;
    do_op(OP_DIV, 1'b0, -32'sd7, 32'd2, got, exp, lat, bc);
    $display("div -7/2 -> %h lat=%0d", got, lat);
    total++;
    if (got !== exp || got !== 64'hFFFF_FFFF_FFFF_FFFD) begin bad++; $display("FAIL div_signed: got %h want fffffffffffffffd", got); end
    total++;
    if (lat != MULDIV_ITERS + 2) begin bad++; $display("FAIL div_latency: got %0d want %0d", lat, MULDIV_ITERS + 2); end
    do_op(OP_DIV, 1'b1, 32'd100, 32'd7, got, exp, lat, bc);
    $display("divu 100/7 -> %h", got);
    total++;
    if (got !== exp || got !== {32'd2, 32'd14}) begin bad++; $display("FAIL divu: got %h want 000000020000000e", got); end
    do_op(OP_DIV, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, got, exp, lat, bc);
    $display("div 80000000/-1 -> %h", got);
    total++;
    if (got !== exp || got !== 64'h0000_0000_8000_0000) begin bad++; $display("FAIL div_ovf: got %h want 0000000080000000", got); end
  endtask

  task automatic test_div_zero();
    logic [63:0] got, exp;
    int lat, bc;
    do_op(OP_DIV, 1'b1, 32'd5, 32'd0, got, exp, lat, bc);
    $display("divu 5/0 -> %h", got);
    total++;
    if (got !== exp || got !== 64'h0000_0005_FFFF_FFFF) begin bad++; $display("FAIL divu_zero: got %h want 00000005ffffffff", got); end
    do_op(OP_DIV, 1'b0, -32'sd5, 32'd0, got, exp, lat, bc);
    $display("div -5/0 -> %h", got);
    total++;
    if (got !== exp || got !== 64'hFFFF_FFFB_0000_0001) begin bad++; $display("FAIL div_zero: got %h want fffffffb00000001", got); end
  endtask

  task automatic test_mthi_mtlo();
    logic [63:0] exp;
    issue(OP_MTHI, 1'b0, 32'h1234, 32'h0, 1'b1);
    exp = exp_q.pop_front();
    $display("mthi 1234 -> hi=%h rv=%b", hi, resp_valid);
    total++;
    if ({hi, lo} !== exp || hi !== 32'h1234 || resp_valid !== 1'b1 || req_ready !== 1'b1)
      begin bad++; $display("FAIL mthi: got hi=%h rv=%b rdy=%b want hi=00001234 rv=1 rdy=1", hi, resp_valid, req_ready); end
    issue(OP_MTLO, 1'b0, 32'h5678, 32'h0, 1'b1);
    exp = exp_q.pop_front();
    $display("mtlo 5678 -> lo=%h rv=%b", lo, resp_valid);
    total++;
    if ({hi, lo} !== exp || {hi, lo} !== 64'h0000_1234_0000_5678 || resp_valid !== 1'b1 || req_ready !== 1'b1)
      begin bad++; $display("FAIL mtlo: got hi=%h lo=%h rv=%b rdy=%b want 00001234/00005678 rv=1 rdy=1", hi, lo, resp_valid, req_ready); end
  endtask

  task automatic test_flush_idle();
    req_valid = 1'b1;
    req_op = OP_MTHI;
    req_a = 32'hDEAD_BEEF;
    flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    flush = 1'b0;
    $display("mthi under flush -> hi=%h rv=%b", hi, resp_valid);
    total++;
    if (hi !== mdl_hi || resp_valid !== 1'b0) begin bad++; $display("FAIL flush_idle: got hi=%h rv=%b want hi=%h rv=0", hi, resp_valid, mdl_hi); end
  endtask

  task automatic test_flush();
    bit seen;
    issue(OP_DIV, 1'b0, 32'd1000, 32'd3, 1'b0);
    // Now after E0; iteration k runs at edge Ek. Flush is sampled at E10.
    repeat (9) @(negedge clock);
    flush = 1'b1;
    @(posedge clock);
    @(negedge clock);
    flush = 1'b0;
    $display("div flushed -> busy=%b rdy=%b rv=%b", busy, req_ready, resp_valid);
    total++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || resp_valid !== 1'b0)
      begin bad++; $display("FAIL flush_idle_next: got busy=%b rdy=%b rv=%b want 0/1/0", busy, req_ready, resp_valid); end
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (resp_valid) seen = 1'b1;
    end
    total++;
    if (seen || {hi, lo} !== {mdl_hi, mdl_lo}) begin bad++; $display("FAIL flush_keep: got hi=%h lo=%h rv_seen=%b want %h/%h 0", hi, lo, seen, mdl_hi, mdl_lo); end
  endtask

  task automatic test_reset_mid();
    issue(OP_DIV, 1'b0, 32'd77, 32'd5, 1'b0);
    repeat (5) @(negedge clock);
    reset_n = 1'b0;
    #1;
    $display("reset mid-div -> hi=%h lo=%h rdy=%b", hi, lo, req_ready);
    total++;
    if ({hi, lo} !== 64'h0 || req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0)
      begin bad++; $display("FAIL reset_mid: got hi=%h lo=%h rdy=%b busy=%b want 0/0/1/0", hi, lo, req_ready, busy); end
    mdl_hi = '0;
    mdl_lo = '0;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    muldiv_op_t ops[5] = '{OP_MUL, OP_MADD, OP_DIV, OP_MTHI, OP_MTLO};
    logic [63:0] got, exp;
    logic [31:0] a, b;
    muldiv_op_t op;
    logic uns;
    int lat, bc;
    for (int i = 0; i < 12; i++) begin
      op  = ops[$urandom_range(0, 4)];
      uns = 1'($urandom_range(0, 1));
      a   = (i == 3) ? 32'h8000_0000 : $urandom;
      b   = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
      if (i % 3 == 0) b = b >> 20;
      do_op(op, uns, a, b, got, exp, lat, bc);
      $display("b2b %0d op=%0d u=%b a=%h b=%h -> %h", i, op, uns, a, b, got);
      total++;
      if (got !== exp) begin bad++; $display("FAIL b2b_%0d: got %h want %h", i, got, exp); end
    end
  endtask

  initial begin
    test_reset();
    test_mul_unsigned();
    test_mul_signed_madd();
    test_div();
    test_div_zero();
    test_mthi_mtlo();
    test_flush_idle();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule
